// File: rtl/tqvp_sprite_frame_sched.sv
// Raster scan timing generator with vblank-deferred sprite config commit and sticky vblank IRQ.
// Outside an active scan a commit request is honoured on the next cycle instead of waiting for vblank.
module tqvp_sprite_frame_sched #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stream_en,
  input  logic        commit_req,
  input  logic        irq_en,
  input  logic        irq_clr,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        commit,
  output logic        commit_pending,
  output logic        irq,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic {OFF, RUN} state_t;

  state_t state;
  state_t state_next;

  logic scan_on;
  logic h_last;
  logic v_last;
  logic vbl;
  logic want_commit;
  logic commit_now;

  always_ff @(posedge clk) begin
    if (rst) state <= OFF;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      OFF:     if (stream_en)  state_next = RUN;
      RUN:     if (!stream_en) state_next = OFF;
      default: state_next = OFF;
    endcase
  end

  assign scan_on     = (state == RUN) && stream_en;
  assign h_last      = (h_cnt == 11'(H_TOTAL - 1));
  assign v_last      = (v_cnt == 10'(V_TOTAL - 1));
  assign vbl         = scan_on && h_last && (v_cnt == 10'(V_ACTIVE - 1));
  assign want_commit = commit_pending | commit_req;
  // Blocking a pulse while one is already out keeps commit from ever lasting two cycles.
  assign commit_now  = (!scan_on || vbl) && want_commit && !commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      visible   <= 1'b0;
      frame_cnt <= '0;
    end else if (!scan_on) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      visible <= 1'b0;
    end else begin
      hsync   <= (h_cnt >= 11'(H_ACTIVE + H_FP)) && (h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC));
      vsync   <= (v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
      visible <= (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit         <= 1'b0;
      commit_pending <= 1'b0;
    end else if (commit_now) begin
      commit         <= 1'b1;
      commit_pending <= 1'b0;
    end else begin
      commit         <= 1'b0;
      commit_pending <= want_commit;
    end
  end

  // A set on vblank takes priority over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst)                irq <= 1'b0;
    else if (vbl && irq_en) irq <= 1'b1;
    else if (irq_clr)       irq <= 1'b0;
  end

endmodule

// File: tb/tb_tqvp_sprite_frame_sched.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares each cycle.
module tb_tqvp_sprite_frame_sched;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk;
  logic        rst;
  logic        stream_en;
  logic        commit_req;
  logic        irq_en;
  logic        irq_clr;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        hsync;
  logic        vsync;
  logic        visible;
  logic        commit;
  logic        commit_pending;
  logic        irq;
  logic [7:0]  frame_cnt;

  tqvp_sprite_frame_sched #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .stream_en(stream_en), .commit_req(commit_req),
    .irq_en(irq_en), .irq_clr(irq_clr), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync(hsync), .vsync(vsync), .visible(visible), .commit(commit),
    .commit_pending(commit_pending), .irq(irq), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int       h;
    int       v;
    bit       hs;
    bit       vs;
    bit       vis;
    bit       cm;
    bit       pend;
    bit       irq;
    bit [7:0] frame;
  } exp_t;

  exp_t expq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Reference model: the raster position is one linear pixel index within the frame.
  bit       m_run = 0;
  int       m_pos = 0;
  bit [7:0] m_frame = 0;
  bit       m_pend = 0;
  bit       m_commit = 0;
  bit       m_irq = 0;
  bit       m_hs = 0, m_vs = 0, m_vis = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic modelStep(input bit r, input bit en, input bit req, input bit ien, input bit clr);
    int  ch, cv;
    bit  scan, vbl, want;
    if (r) begin
      m_run = 0; m_pos = 0; m_frame = 0; m_pend = 0; m_commit = 0; m_irq = 0;
      m_hs = 0; m_vs = 0; m_vis = 0;
      return;
    end
    ch   = m_pos % HT;
    cv   = m_pos / HT;
    scan = m_run && en;
    vbl  = scan && (m_pos == VA * HT - 1);
    want = m_pend || req;
    if ((!scan || vbl) && want && !m_commit) begin
      m_commit = 1; m_pend = 0;
    end else begin
      m_commit = 0; m_pend = want;
    end
    if (vbl && ien) m_irq = 1;
    else if (clr)   m_irq = 0;
    if (scan) begin
      m_hs  = (ch >= HA + HF) && (ch < HA + HF + HS);
      m_vs  = (cv >= VA + VF) && (cv < VA + VF + VS);
      m_vis = (ch < HA) && (cv < VA);
      m_pos = m_pos + 1;
      if (m_pos == HT * VT) begin
        m_pos   = 0;
        m_frame = m_frame + 8'd1;
      end
    end else begin
      m_hs = 0; m_vs = 0; m_vis = 0; m_pos = 0;
    end
    m_run = en;
  endtask

  task automatic applyStimulus(input bit r, input bit en, input bit req, input bit ien, input bit clr);
    exp_t e;
    @(negedge clk);
    rst = r; stream_en = en; commit_req = req; irq_en = ien; irq_clr = clr;
    modelStep(r, en, req, ien, clr);
    e.h = m_pos % HT; e.v = m_pos / HT;
    e.hs = m_hs; e.vs = m_vs; e.vis = m_vis;
    e.cm = m_commit; e.pend = m_pend; e.irq = m_irq; e.frame = m_frame;
    expq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared field by field.
  logic prevCommit = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("h_cnt", 32'(h_cnt), 32'(e.h));
        checkOutput("v_cnt", 32'(v_cnt), 32'(e.v));
        checkOutput("hsync", 32'(hsync), 32'(e.hs));
        checkOutput("vsync", 32'(vsync), 32'(e.vs));
        checkOutput("visible", 32'(visible), 32'(e.vis));
        checkOutput("commit", 32'(commit), 32'(e.cm));
        checkOutput("commit_pending", 32'(commit_pending), 32'(e.pend));
        checkOutput("irq", 32'(irq), 32'(e.irq));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(e.frame));
        checkOutput("commit_no_repeat", 32'(prevCommit & commit), 32'd0);
        prevCommit = commit;
      end
    end
  end

  initial begin
    bit en;
    rst = 1; stream_en = 0; commit_req = 0; irq_en = 0; irq_clr = 0;

    repeat (2) applyStimulus(1, 0, 0, 0, 0);
    // Two full frames: deferred request, request during the pulse, clear racing the set, later clear.
    for (int i = 0; i < 200; i++)
      applyStimulus(0, 1, (i == 4) || (i == 57), 1, (i == 56) || (i == 120));
    // Drop the scan mid-frame with a request waiting.
    for (int k = 0; k < 200 && !(m_run && m_pos == 2 * HT + 5); k++)
      applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    // Requests while stopped, including back-to-back ones.
    applyStimulus(0, 0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    // Reset mid-frame with a request pending.
    for (int k = 0; k < 40; k++)
      applyStimulus(0, 1, (k == 20), 1, 0);
    applyStimulus(1, 1, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (en) begin
        if ($urandom_range(249) == 0) en = 0;
      end else if ($urandom_range(7) == 0) begin
        en = 1;
      end
      applyStimulus($urandom_range(799) == 0, en, $urandom_range(39) == 0,
                    $urandom_range(3) != 0, $urandom_range(29) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/tqvp_sprite_frame_sched.md
TQVP_SPRITE_FRAME_SCHED -- requirements
Module: tqvp_sprite_frame_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 1024 visible pixels/line; H_FP 24 h front porch; H_SYNC 136 hsync width; H_BP 160 h back porch; V_ACTIVE 768 visible lines; V_FP 3; V_SYNC 6; V_BP 29. H_TOTAL and V_TOTAL are each the sum of their four parameters.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk input 1: only clock.
- rst input 1: reset, synchronous, active-high.
- stream_en input 1: scan enable.
- commit_req input 1: one-cycle request to commit shadow sprite config.
- irq_en input 1: vblank interrupt enable.
- irq_clr input 1: one-cycle interrupt clear.
- h_cnt output 11: pixel counter.
- v_cnt output 10: line counter.
- hsync output 1: active-high.
- vsync output 1: active-high.
- visible output 1: active pixel.
- commit output 1: one-cycle pulse that copies shadow config to live config.
- commit_pending output 1: request waiting for vblank.
- irq output 1: sticky vblank interrupt.
- frame_cnt output 8: completed frames.
REQ-003 SHALL have one clock domain (clk), with reset synchronous and active-high on rst; all outputs are registered.

Function
REQ-004 SHALL implement a 2-state scan FSM: OFF and RUN.
- OFF->RUN when stream_en=1.
- RUN->OFF when stream_en=0.
REQ-005 In OFF, h_cnt, v_cnt, hsync, vsync and visible SHALL be 0, and frame_cnt SHALL hold.
REQ-006 On the OFF->RUN edge, the counters SHALL remain 0; counting starts on the following edge.
REQ-007 In RUN with stream_en=1, h_cnt SHALL increment by 1 per clock.
- At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
- At v_cnt=V_TOTAL-1 on an h wrap, v_cnt wraps to 0 and frame_cnt increments (mod 256).
REQ-008 On RUN->OFF, counters and sync outputs SHALL be forced to 0 on that same edge; a partial frame does not increment frame_cnt.
REQ-009 hsync, vsync and visible SHALL each be registered decodes of the previous cycle's counters (exactly one clock of lag).
- hsync: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- visible: h < H_ACTIVE and v < V_ACTIVE.
REQ-010 Event vbl SHALL be defined as RUN and stream_en=1 and h_cnt=H_TOTAL-1 and v_cnt=V_ACTIVE-1.
REQ-011 Commit scheduling in RUN:
- commit_req sets commit_pending.
- On vbl with (commit_pending or commit_req), commit=1 for exactly the next cycle (coincident with h_cnt=0, v_cnt=V_ACTIVE), and commit_pending clears.
REQ-012 commit_req arriving during the commit pulse cycle SHALL set commit_pending for the next vbl and SHALL NOT extend the pulse.
REQ-013 In OFF, or on a RUN->OFF transition, a pending or new request SHALL produce a commit pulse on the next cycle and clear commit_pending; with no scan active, there is no waiting.
REQ-014 commit SHALL never be high for two consecutive cycles.
REQ-015 irq SHALL set on vbl when irq_en=1, becoming visible in the same cycle as the commit pulse.
REQ-016 irq_clr SHALL clear irq; when set and clear happen on the same edge, set wins.
REQ-017 irq SHALL hold its value in OFF until cleared; irq_en=0 does not clear it.

Reset
REQ-018 With rst=1 on an edge, the block SHALL go to state OFF and all outputs SHALL be 0: h_cnt, v_cnt, hsync, vsync, visible, commit, commit_pending, irq, frame_cnt.
REQ-019 Reset mid-frame SHALL discard any pending commit without a pulse; rst overrides all other inputs.

Verification
All scenarios use params H 8/2/2/2 (H_TOTAL=14) and V 4/1/1/1 (V_TOTAL=7).
REQ-020 Timing: rst, then stream_en=1 held -> h_cnt sequences 0..13; hsync high for exactly 2 cycles per line, lagging h_cnt=10,11 by one clock; vsync high for 14 cycles per frame; frame_cnt=1 after 1+98 cycles.
REQ-021 Commit deferral: commit_req pulse at h_cnt=3, v_cnt=0 -> commit_pending=1 until a single commit pulse at h_cnt=0, v_cnt=4; commit is 0 everywhere else in the frame.
REQ-022 Request in OFF, and request during the pulse:
- commit_req with stream_en=0 -> commit=1 the next cycle only; commit_pending never asserts.
- commit_req in the pulse cycle -> second pulse exactly 98 cycles later.
REQ-023 IRQ: irq_en=1 -> irq rises with h_cnt=0, v_cnt=4; irq_clr in the same cycle as the set -> irq stays 1; a later irq_clr -> 0.
REQ-024 Disable and reset:
- stream_en dropped at v_cnt=2 with a request pending -> next cycle counters=0, commit=1, frame_cnt unchanged.
- rst mid-frame with a request pending -> all outputs 0 and no commit pulse.
